// File: rtl/rvfi_stim_gen_if.sv
// RVFI retirement-trace bundle: the subset of RVFI signals seen by the
// register-consistency checkers.
interface rvfi_stim_gen_if;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [4:0]  rvfi_rs1_addr;
    logic [31:0] rvfi_rs1_rdata;
    logic [4:0]  rvfi_rs2_addr;
    logic [31:0] rvfi_rs2_rdata;

    modport master (
        output rvfi_valid, rvfi_order,
        output rvfi_rd_addr, rvfi_rd_wdata,
        output rvfi_rs1_addr, rvfi_rs1_rdata,
        output rvfi_rs2_addr, rvfi_rs2_rdata
    );

    modport slave (
        input rvfi_valid, rvfi_order,
        input rvfi_rd_addr, rvfi_rd_wdata,
        input rvfi_rs1_addr, rvfi_rs1_rdata,
        input rvfi_rs2_addr, rvfi_rs2_rdata
    );
endinterface

// File: rtl/rvfi_stim_gen.sv
// LFSR-driven RVFI retirement generator with a shadow register file and one-shot rs1 error injection.
// state | meaning:  IDLE | disabled, LFSR frozen;  EMIT | retire one instruction;  GAP | idle cycles between retirements
module rvfi_stim_gen #(
    parameter logic [31:0] SEED      = 32'hACE1_2025,
    parameter int unsigned GAP_W     = 2,
    parameter logic [4:0]  FOCUS_REG = 5'd7
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            inject_err_i,
    rvfi_stim_gen_if.master rvfi,
    output logic            err_armed_o,
    output logic            err_done_o
);

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d, gap_val;
    logic [63:0]      order_q;
    logic [31:0]      rf_q [32];

    logic        emit;
    logic        fire;
    logic        armed_d;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] wdata;
    logic [31:0] rs1_val, rs2_val;

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        emit      = 1'b0;
        gap_val   = lfsr_q[31 -: GAP_W];
        lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

        case (state_q)
            IDLE: begin
                if (enable_i) state_d = EMIT;
            end
            EMIT: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else begin
                    emit = 1'b1;
                    if (gap_val != '0) begin
                        gap_cnt_d = gap_val;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = EMIT;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Field decode; reads see the register file before this retirement's write.
    always_comb begin
        rs1     = lfsr_q[20] ? FOCUS_REG : lfsr_q[4:0];
        rs2     = lfsr_q[21] ? FOCUS_REG : lfsr_q[9:5];
        rd      = lfsr_q[22] ? FOCUS_REG : lfsr_q[14:10];
        wdata   = (rd == 5'd0) ? 32'd0 : (lfsr_q ^ {lfsr_q[15:0], lfsr_q[31:16]});
        rs1_val = rf_q[rs1];
        rs2_val = rf_q[rs2];
        fire    = emit && err_armed_o && (rs1 != 5'd0);
        armed_d = inject_err_i || (err_armed_o && !fire);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (emit && (rd != 5'd0)) begin
            rf_q[rd] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q             <= IDLE;
            gap_cnt_q           <= '0;
            lfsr_q              <= SEED;
            order_q             <= '0;
            err_armed_o         <= 1'b0;
            err_done_o          <= 1'b0;
            rvfi.rvfi_valid     <= 1'b0;
            rvfi.rvfi_order     <= '0;
            rvfi.rvfi_rd_addr   <= '0;
            rvfi.rvfi_rd_wdata  <= '0;
            rvfi.rvfi_rs1_addr  <= '0;
            rvfi.rvfi_rs1_rdata <= '0;
            rvfi.rvfi_rs2_addr  <= '0;
            rvfi.rvfi_rs2_rdata <= '0;
        end else begin
            state_q         <= state_d;
            gap_cnt_q       <= gap_cnt_d;
            err_armed_o     <= armed_d;
            err_done_o      <= fire;
            rvfi.rvfi_valid <= emit;
            if (state_q != IDLE) lfsr_q <= lfsr_d;
            if (emit) begin
                order_q             <= order_q + 64'd1;
                rvfi.rvfi_order     <= order_q;
                rvfi.rvfi_rd_addr   <= rd;
                rvfi.rvfi_rd_wdata  <= wdata;
                rvfi.rvfi_rs1_addr  <= rs1;
                rvfi.rvfi_rs1_rdata <= rs1_val ^ {31'd0, fire};
                rvfi.rvfi_rs2_addr  <= rs2;
                rvfi.rvfi_rs2_rdata <= rs2_val;
            end
        end
    end

endmodule

// File: doc/rvfi_stim_gen.md
# rvfi_stim_gen

Synthesizable RVFI retirement-trace generator that drives the same signals the register-consistency checkers observe, replacing ibex_top as the stimulus source for standalone checker bring-up. It keeps a 32-entry shadow register file, so every emitted rs1/rs2 read value equals the last value written to that register. It also supports one-shot error injection to confirm that checkers fire. Register selection is biased toward a configurable focus register so the x7 checkers are exercised densely.

## Interface
- SEED, 32'hACE1_2025, LFSR reset value; must be nonzero
- GAP_W, 2, width of the idle-gap field; gap range is 0..2^GAP_W-1 cycles
- FOCUS_REG, 5'd7, register index that biased selections are forced to
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- enable_i  in  1  generation enable, level-sensitive
- inject_err_i  in  1  single-cycle pulse; arms one corrupted rs1 read
- rvfi_valid  out  1  retirement strobe, one cycle per retirement
- rvfi_order  out  64  retirement index
- rvfi_rd_addr  out  5  destination register
- rvfi_rd_wdata  out  32  value written to rd; 0 when rd is 0
- rvfi_rs1_addr  out  5  source 1 index
- rvfi_rs1_rdata  out  32  source 1 value
- rvfi_rs2_addr  out  5  source 2 index
- rvfi_rs2_rdata  out  32  source 2 value
- err_armed_o  out  1  injection pending
- err_done_o  out  1  one-cycle pulse, registered with the corrupted retirement

## Operation
- **LFSR:** 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (toggle mask 32'h8020_0003).
  - Steps once per cycle while state is not IDLE.
  - `L` denotes the current LFSR value.
- **FSM states:** IDLE, EMIT, GAP.
  - IDLE: enable_i=1 → EMIT.
  - EMIT: emits one retirement. If gap = L[31 -: GAP_W] is 0 → EMIT; otherwise load the gap counter with gap and go to GAP.
  - GAP: decrement the counter; at count 1 → EMIT.
  - enable_i=0 in any state → IDLE on the next edge. No retirement is emitted on that edge.
- **Field derivation in EMIT (all from L):**
  - rs1 = L[20] ? FOCUS_REG : L[4:0]
  - rs2 = L[21] ? FOCUS_REG : L[9:5]
  - rd = L[22] ? FOCUS_REG : L[14:10]
  - wdata = L ^ {L[15:0], L[31:16]}, forced to 0 when rd=0.
- **Shadow register file:** 32x32, reset to all zeros. x0 is never written and always reads 0.
  - Reads are read-before-write: rs1/rs2 rdata are taken from the register file contents before this retirement's write.
  - This holds when rs==rd: the old value is reported.
  - The rd write lands on the same edge that registers the outputs.
- **rvfi_order:** starts at 0, increments by 1 after each retirement, wraps modulo 2^64.
- **Error injection:**
  - An inject_err_i pulse sets err_armed_o.
  - The first subsequent retirement with rs1≠0 reports rs1_rdata with bit 0 inverted, pulses err_done_o, and clears err_armed_o.
  - The shadow register file is never corrupted.
  - A pulse while already armed has no extra effect.
  - A pulse coinciding with a qualifying retirement arms for the next qualifying one.
  - Armed state survives enable_i=0.

## Timing
- All outputs are registered.
- rvfi_valid is high exactly one cycle per EMIT. Consecutive valids are possible when gap=0.
- The rvfi_* data outputs hold their last values while rvfi_valid=0.
- First retirement: rvfi_valid rises on the second edge after enable_i is sampled high. Edge 1 is IDLE→EMIT; edge 2 registers the outputs.
- **Reset values (asynchronous):**
  - rvfi_valid=0, rvfi_order=0, all addr/data outputs=0
  - err_armed_o=0, err_done_o=0
  - LFSR=SEED, state=IDLE, shadow register file all 0
- Reset mid-stream aborts immediately. rvfi_order restarts at 0 and the trace repeats identically from SEED.

## Test plan
- **Reset:** assert rst_ni=0 mid-GAP → all outputs 0 with no clock edge. Release → first retirement has rvfi_order=0, and the trace matches a reference model seeded with 32'hACE1_2025.
- **Consistency:** enable for 10,000 cycles with a scoreboard → every rs1/rs2 rdata equals the last rd_wdata to that index (0 if unwritten). rd=0 always carries wdata=0.
- **Same-register hazard:** wait for a retirement with rd=rs1=7 → rs1_rdata equals the previous x7 value; the next read of x7 returns this retirement's wdata.
- **Injection:** pulse inject_err_i at cycle 50 → exactly one later retirement has rs1_rdata = expected^1 with err_done_o=1 on that cycle; err_armed_o drops; a bound x7 checker fails only if that rs1 is 7.
- **Enable gating:** drop enable_i during GAP for 20 cycles → no valids; LFSR is frozen; resumption continues the sequence with the next rvfi_order and no skipped index.
- **Gap bound:** GAP_W=2 over 1,000 retirements → inter-valid gaps are always within 0..3 idle cycles, and the values 0 and 3 each occur at least once.
